// File: rtl/dispatch_buf.sv
// dispatch_buf: in-order 2-entry dispatch buffer between rename and the
// reservation stations. Packets are converted to RS entries on entry, keep
// their source-ready bits current by snooping the FU writeback buses, and
// leave from the head toward the RS selected by their functional-unit type.

package dispatch_pkg;

  localparam int PREG_W = 6;
  localparam int AREG_W = 5;
  localparam int ROB_W  = 4;
  localparam int OP_W   = 4;
  localparam int XLEN   = 32;

  typedef enum logic [1:0] {
    FU_ALU  = 2'd0,
    FU_BRU  = 2'd1,
    FU_LSU  = 2'd2,
    FU_NONE = 2'd3
  } fu_type_t;

  // Packet coming out of rename.
  typedef struct packed {
    logic              valid;
    fu_type_t          fu_type;
    logic [OP_W-1:0]   op;
    logic [AREG_W-1:0] rs1;
    logic [AREG_W-1:0] rs2;
    logic [AREG_W-1:0] rd;
    logic              rs1_used;
    logic              rs2_used;
    logic              rd_used;
    logic [PREG_W-1:0] prs1;
    logic [PREG_W-1:0] prs2;
    logic [PREG_W-1:0] prd;
    logic [PREG_W-1:0] old_prd;
    logic              prs1_ready;
    logic              prs2_ready;
    logic [ROB_W-1:0]  rob_tag;
    logic [XLEN-1:0]   imm;
  } rename_pkt_t;

  // Entry written into a reservation station.
  typedef struct packed {
    logic              valid;
    fu_type_t          fu_type;
    logic [OP_W-1:0]   op;
    logic              rs1_used;
    logic              rs2_used;
    logic              rd_used;
    logic [PREG_W-1:0] prs1;
    logic              prs1_ready;
    logic [PREG_W-1:0] prs2;
    logic              prs2_ready;
    logic [PREG_W-1:0] prd;
    logic [ROB_W-1:0]  rob_tag;
    logic [XLEN-1:0]   imm;
  } rs_entry_t;

  // Functional-unit completion broadcast.
  typedef struct packed {
    logic              valid;
    logic              rd_used;
    logic [PREG_W-1:0] prd;
    logic [ROB_W-1:0]  rob_tag;
    logic [XLEN-1:0]   data;
  } wb_pkt_t;

  // Buffer occupancy doubles as the only state of the block.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_t;

endpackage

module dispatch_buf
  import dispatch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  rename_pkt_t       in_pkt,
  output logic              in_ready,
  input  wb_pkt_t           wb_alu,
  input  wb_pkt_t           wb_lsu,
  input  wb_pkt_t           wb_bru,
  output rs_entry_t         alu_rs_entry,
  output rs_entry_t         bru_rs_entry,
  output rs_entry_t         lsu_rs_entry,
  input  logic              alu_rs_ready,
  input  logic              bru_rs_ready,
  input  logic              lsu_rs_ready,
  output logic              none_done_valid,
  output logic [ROB_W-1:0]  none_done_tag
);

  rs_entry_t mem [DEPTH];
  occ_t      count;
  occ_t      count_next;
  logic      head_ptr;
  logic      tail_ptr;
  logic      push;
  logic      pop;
  logic      has_head;
  rs_entry_t push_entry;
  rs_entry_t head_view;

  // Fields that rename provides but the RS never needs, plus writeback
  // payload that only matters to the register file.
  logic unused_bits;
  assign unused_bits = ^{in_pkt.rs1, in_pkt.rs2, in_pkt.rd, in_pkt.old_prd,
                         wb_alu.rob_tag, wb_alu.data,
                         wb_lsu.rob_tag, wb_lsu.data,
                         wb_bru.rob_tag, wb_bru.data};

  // A source wakes when any bus completes a producer writing that register.
  function automatic logic wake_hit(input logic [PREG_W-1:0] prs,
                                    input wb_pkt_t a,
                                    input wb_pkt_t b,
                                    input wb_pkt_t c);
    return (a.valid && a.rd_used && (a.prd == prs)) ||
           (b.valid && b.rd_used && (b.prd == prs)) ||
           (c.valid && c.rd_used && (c.prd == prs));
  endfunction

  // Acceptance never looks at RS ready, keeping rename off the RS timing path.
  assign in_ready = (count != OCC_FULL) && !flush && !rst;
  assign push     = in_pkt.valid && in_ready;
  assign has_head = (count != OCC_EMPTY);

  // Convert the incoming rename packet into its stored form, applying any
  // wakeup that arrives in the very cycle it is pushed.
  always_comb begin
    push_entry            = '0;
    push_entry.valid      = 1'b1;
    push_entry.fu_type    = in_pkt.fu_type;
    push_entry.op         = in_pkt.op;
    push_entry.rs1_used   = in_pkt.rs1_used;
    push_entry.rs2_used   = in_pkt.rs2_used;
    push_entry.rd_used    = in_pkt.rd_used;
    push_entry.prs1       = in_pkt.prs1;
    push_entry.prs2       = in_pkt.prs2;
    push_entry.prd        = in_pkt.prd;
    push_entry.rob_tag    = in_pkt.rob_tag;
    push_entry.imm        = in_pkt.imm;
    push_entry.prs1_ready = in_pkt.prs1_ready || !in_pkt.rs1_used ||
                            wake_hit(in_pkt.prs1, wb_alu, wb_lsu, wb_bru);
    push_entry.prs2_ready = in_pkt.prs2_ready || !in_pkt.rs2_used ||
                            wake_hit(in_pkt.prs2, wb_alu, wb_lsu, wb_bru);
  end

  // Present the head entry with this cycle's wakeups already folded in.
  always_comb begin
    head_view            = mem[head_ptr];
    head_view.prs1_ready = mem[head_ptr].prs1_ready ||
                           wake_hit(mem[head_ptr].prs1, wb_alu, wb_lsu, wb_bru);
    head_view.prs2_ready = mem[head_ptr].prs2_ready ||
                           wake_hit(mem[head_ptr].prs2, wb_alu, wb_lsu, wb_bru);
  end

  // Steer the head to its RS, retire FU_NONE packets directly, and decide pop.
  always_comb begin
    alu_rs_entry       = head_view;
    bru_rs_entry       = head_view;
    lsu_rs_entry       = head_view;
    alu_rs_entry.valid = 1'b0;
    bru_rs_entry.valid = 1'b0;
    lsu_rs_entry.valid = 1'b0;
    none_done_valid    = 1'b0;
    none_done_tag      = '0;
    pop                = 1'b0;
    if (has_head && !flush) begin
      case (head_view.fu_type)
        FU_ALU: begin
          alu_rs_entry.valid = 1'b1;
          pop                = alu_rs_ready;
        end
        FU_BRU: begin
          bru_rs_entry.valid = 1'b1;
          pop                = bru_rs_ready;
        end
        FU_LSU: begin
          lsu_rs_entry.valid = 1'b1;
          pop                = lsu_rs_ready;
        end
        default: begin
          none_done_valid = 1'b1;
          none_done_tag   = head_view.rob_tag;
          pop             = 1'b1;
        end
      endcase
    end
  end

  // Occupancy transitions; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = (count == OCC_EMPTY) ? OCC_ONE : OCC_FULL;
      2'b01:   count_next = (count == OCC_FULL) ? OCC_ONE : OCC_EMPTY;
      default: count_next = count;
    endcase
  end

  // Occupancy and pointer registers; flush empties the buffer outright.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= OCC_EMPTY;
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
    end else if (flush) begin
      count    <= OCC_EMPTY;
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
    end else begin
      count <= count_next;
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
    end
  end

  // Entry storage: wakeups latch into every slot, and the push overwrites
  // the tail slot with its already-woken contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wake_hit(mem[i].prs1, wb_alu, wb_lsu, wb_bru)) mem[i].prs1_ready <= 1'b1;
        if (wake_hit(mem[i].prs2, wb_alu, wb_lsu, wb_bru)) mem[i].prs2_ready <= 1'b1;
      end
      if (push) mem[tail_ptr] <= push_entry;
    end
  end

endmodule
